// File: rtl/inst_decode_stage_if.sv
// Fetch-side and decode-side handshake bundle for inst_decode_stage.
// master = the fetch/execute environment, slave = the decode stage.
interface inst_decode_stage_if #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_inst;
  logic [XLEN-1:0]           in_pc;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out_pc;
  logic [6:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [2:0]                funct3;
  logic [6:0]                funct7;
  logic [XLEN-1:0]           imm;
  logic [2:0]                imm_type;
  logic                      illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, rs1, rs2, rd,
           funct3, funct7, imm, imm_type, illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, rs1, rs2, rd,
           funct3, funct7, imm, imm_type, illegal
  );
endinterface

// File: rtl/inst_decode_stage.sv
// Registered RV32I decode stage: field split, immediate formatting, illegal
// opcode flag, behind a two-entry (output + skid) valid/ready buffer.
module inst_decode_stage #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inst_decode_stage_if.slave    bus
);

  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [XLEN-1:0]           imm;
    logic [2:0]                imm_type;
    logic                      illegal;
  } dec_t;

  dec_t        dec;
  logic [31:0] inst;
  logic [31:0] imm32;

  dec_t out_q, out_d, skid_q, skid_d;
  logic out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic accept, consume;

  // Every format is built as a 32-bit value whose bit 31 is inst[31], so a
  // single signed widening covers XLEN=32 and XLEN=64 alike.
  always_comb begin
    inst         = bus.in_inst;
    imm32        = '0;
    dec          = '0;
    dec.pc       = bus.in_pc;
    dec.opcode   = inst[6:0];
    dec.rs1      = REG_ADDR_WIDTH'(inst[19:15]);
    dec.rs2      = REG_ADDR_WIDTH'(inst[24:20]);
    dec.rd       = REG_ADDR_WIDTH'(inst[11:7]);
    dec.funct3   = inst[14:12];
    dec.funct7   = inst[31:25];
    dec.imm_type = IMM_R;
    dec.illegal  = 1'b0;
    case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        dec.imm_type = IMM_I;
        imm32        = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        dec.imm_type = IMM_S;
        imm32        = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        dec.imm_type = IMM_B;
        imm32        = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.imm_type = IMM_U;
        imm32        = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.imm_type = IMM_J;
        imm32        = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b0110011: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  // in_ready depends only on the skid flop, so out_ready never reaches it.
  assign bus.in_ready = ~skid_vld_q;
  assign accept       = bus.in_valid & ~skid_vld_q & ~bus.flush;
  assign consume      = out_vld_q & bus.out_ready;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (consume) begin
        out_vld_d  = skid_vld_q;
        out_d      = skid_vld_q ? skid_q : out_q;
        skid_vld_d = 1'b0;
      end
      // accept implies skid empty, so it never races the skid->output move
      if (accept) begin
        if (!out_vld_q || consume) begin
          out_d     = dec;
          out_vld_d = 1'b1;
        end else begin
          skid_d     = dec;
          skid_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_pc    = out_q.pc;
  assign bus.opcode    = out_q.opcode;
  assign bus.rs1       = out_q.rs1;
  assign bus.rs2       = out_q.rs2;
  assign bus.rd        = out_q.rd;
  assign bus.funct3    = out_q.funct3;
  assign bus.funct7    = out_q.funct7;
  assign bus.imm       = out_q.imm;
  assign bus.imm_type  = out_q.imm_type;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed scenarios plus a randomized run
// against a queue-based occupancy model and arithmetic immediate model.
module tb_inst_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_decode_stage_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) bus ();
  inst_decode_stage_if #(.XLEN(64), .REG_ADDR_WIDTH(5)) b64 ();

  inst_decode_stage #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  inst_decode_stage #(.XLEN(64), .REG_ADDR_WIDTH(5)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  assign b64.flush     = bus.flush;
  assign b64.in_valid  = bus.in_valid;
  assign b64.in_inst   = bus.in_inst;
  assign b64.in_pc     = {32'b0, bus.in_pc};
  assign b64.out_ready = bus.out_ready;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } beat_t;
  beat_t q[$];
  int total = 0;
  int bad = 0;

  logic [99:0] dut_vec;
  assign dut_vec = {bus.out_pc, bus.opcode, bus.rs1, bus.rs2, bus.rd, bus.funct3,
                    bus.funct7, bus.imm, bus.imm_type, bus.illegal};

  function automatic int exp_type(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: return 1;
      7'h23: return 2;
      7'h63: return 3;
      7'h37, 7'h17: return 4;
      7'h6F: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic bit exp_illegal(input logic [31:0] i);
    return exp_type(i) == 0 && i[6:0] != 7'h33;
  endfunction

  // Immediates rebuilt from arithmetic shifts/masks of the signed word.
  function automatic longint exp_imm(input logic [31:0] i);
    longint s = longint'($signed(i));
    case (exp_type(i))
      1: return s >>> 20;
      2: return ((s >>> 25) << 5) | ((s >> 7) & 31);
      3: return ((s >>> 31) << 12) | (((s >> 7) & 1) << 11) | (((s >> 25) & 63) << 5) | (((s >> 8) & 15) << 1);
      4: return s & ~longint'(4095);
      5: return ((s >>> 31) << 20) | (((s >> 12) & 255) << 12) | (((s >> 20) & 1) << 11) | (((s >> 21) & 1023) << 1);
      default: return 0;
    endcase
  endfunction

  function automatic logic [99:0] exp_vec(input logic [31:0] i, input logic [31:0] pc);
    longint m = exp_imm(i);
    int t = exp_type(i);
    logic [31:0] m32 = m[31:0];
    logic [2:0] t3 = t[2:0];
    return {pc, i[6:0], i[19:15], i[24:20], i[11:7], i[14:12], i[31:25], m32, t3, exp_illegal(i)};
  endfunction

  task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // Advance one edge and update the occupancy model from the stimulus.
  task automatic tick(output bit acc);
    bit cons;
    beat_t b;
    acc    = bus.in_valid && !bus.flush && q.size() < 2;
    cons   = q.size() > 0 && bus.out_ready;
    b.inst = bus.in_inst;
    b.pc   = bus.in_pc;
    @(posedge clk);
    if (bus.flush) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 32'h0, 32'h0, 0, 0);
    #12;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
    total++; if (dut_vec !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", dut_vec); end
    total++; if (b64.imm !== 64'h0) begin bad++; $display("FAIL reset_imm64 got=%h exp=0", b64.imm); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    bit a;
    drive(1, 32'hFFF10093, 32'h100, 1, 0);
    tick(a);
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", bus.out_valid); end
    total++;
    if (bus.rd !== 5'd1 || bus.rs1 !== 5'd2 || bus.imm !== 32'hFFFFFFFF || bus.imm_type !== 3'd1 ||
        bus.illegal !== 1'b0 || bus.out_pc !== 32'h100) begin
      bad++; $display("FAIL addi_fields got rd=%0d rs1=%0d imm=%h type=%0d ill=%b pc=%h exp 1 2 ffffffff 1 0 100",
                      bus.rd, bus.rs1, bus.imm, bus.imm_type, bus.illegal, bus.out_pc);
    end
    tick(a);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4] = '{32'h00512423, 32'hFE000EE3, 32'h123451B7, 32'h001000EF};
    logic [31:0] imms[4] = '{32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
    logic [2:0]  typs[4] = '{3'd2, 3'd3, 3'd4, 3'd5};
    bit a;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) drive(1, ins[k], 32'h200 + 32'(4 * k), 1, 0);
      else       drive(0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      if (k > 0) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.imm !== imms[k-1] || bus.imm_type !== typs[k-1]) begin
          bad++; $display("FAIL b2b_imm%0d got v=%b imm=%h type=%0d exp v=1 imm=%h type=%0d",
                          k - 1, bus.out_valid, bus.imm, bus.imm_type, imms[k-1], typs[k-1]);
        end
        if (k == 2) begin
          total++;
          if (b64.imm !== 64'hFFFFFFFFFFFFFFFC) begin
            bad++; $display("FAIL b2b_imm64 got=%h exp=fffffffffffffffc", b64.imm);
          end
        end
      end
      tick(a);
    end
  endtask

  task automatic test_illegal();
    bit a;
    drive(1, 32'h0000007F, 32'h300, 1, 0);
    tick(a);
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    total++;
    if (bus.illegal !== 1'b1 || bus.imm !== 32'h0 || bus.imm_type !== 3'd0 || b64.illegal !== 1'b1 || b64.imm !== 64'h0) begin
      bad++; $display("FAIL illegal got ill=%b imm=%h type=%0d ill64=%b imm64=%h exp 1 0 0 1 0",
                      bus.illegal, bus.imm, bus.imm_type, b64.illegal, b64.imm);
    end
    tick(a);
  endtask

  task automatic test_stall();
    logic [31:0] ins[4] = '{32'h00A00513, 32'h00B50633, 32'h40C686B3, 32'hFE5FF06F};
    logic [99:0] snap = '0;
    int idx = 0, pops = 0;
    bit a;
    for (int c = 0; c < 30 && pops < 4; c++) begin
      drive(idx < 4, (idx < 4) ? ins[idx] : 32'h0, 32'h400 + 32'(4 * idx), c >= 3, 0);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) pops++;
      if (c == 2) begin
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", bus.in_ready); end
        total++; if (dut_vec !== snap) begin bad++; $display("FAIL stall_hold got=%h exp=%h", dut_vec, snap); end
      end
      if (c == 1) snap = dut_vec;
      total++; if (bus.in_ready !== (q.size() < 2)) begin bad++; $display("FAIL stall_rdy%0d got=%b exp=%b", c, bus.in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        total++;
        if (bus.out_valid !== 1'b1 || dut_vec !== exp_vec(q[0].inst, q[0].pc)) begin
          bad++; $display("FAIL stall_data%0d got=%h exp=%h", c, dut_vec, exp_vec(q[0].inst, q[0].pc));
        end
      end
      tick(a);
      if (a) idx++;
    end
    total++; if (pops != 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", pops); end
  endtask

  task automatic test_flush();
    bit a;
    drive(1, 32'h00100093, 32'h500, 0, 0); tick(a);
    drive(1, 32'h00200113, 32'h504, 0, 0); tick(a);
    drive(1, 32'h00300193, 32'h508, 0, 1); tick(a);
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", bus.in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick(a);
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak%0d got=%b exp=0", c, bus.out_valid); end
    end
    tick(a);
  endtask

  task automatic test_async_reset();
    bit a;
    drive(1, 32'h12345037, 32'h600, 0, 0); tick(a);
    drive(1, 32'hFFF00067, 32'h604, 0, 0); tick(a);
    drive(0, 32'h0, 32'h0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || b64.imm !== 64'h0) begin
      bad++; $display("FAIL arst_clear got data=%h v=%b r=%b exp 0 0 1", dut_vec, bus.out_valid, bus.in_ready);
    end
    q.delete();
    #1 rst_n = 1'b1;
    drive(1, 32'hFFF10093, 32'h700, 1, 0);
    tick(a);
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || dut_vec !== exp_vec(32'hFFF10093, 32'h700)) begin
      bad++; $display("FAIL arst_first got v=%b data=%h exp=%h", bus.out_valid, dut_vec, exp_vec(32'hFFF10093, 32'h700));
    end
    tick(a);
  endtask

  task automatic test_random();
    logic [6:0] ops[14] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00, 7'h5B};
    logic [31:0] r;
    bit a;
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      drive($urandom_range(0, 9) < 7, {r[31:7], ops[$urandom_range(0, 13)]}, $urandom(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
      @(negedge clk);
      total++; if (bus.out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid%0d got=%b exp=%b", c, bus.out_valid, q.size() > 0); end
      total++; if (bus.in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready%0d got=%b exp=%b", c, bus.in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        total++;
        if (dut_vec !== exp_vec(q[0].inst, q[0].pc)) begin
          bad++; $display("FAIL rnd_data%0d got=%h exp=%h", c, dut_vec, exp_vec(q[0].inst, q[0].pc));
        end
        total++;
        if (b64.imm !== 64'(exp_imm(q[0].inst))) begin
          bad++; $display("FAIL rnd_imm64_%0d got=%h exp=%h", c, b64.imm, 64'(exp_imm(q[0].inst)));
        end
      end
      tick(a);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_illegal();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
